// File: rtl/ub_arb_pkg.sv
// Unified Buffer access arbiter: shared types and helpers.
// Owner states and a one-hot to index encoder.
package ub_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  function automatic logic [4:0] onehot2idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ub_access_arbiter_picker.sv
// Circular priority picker: first set request at or after mask_start.
// Purely combinational, one-hot result plus valid.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] mask_start,
  output logic [N-1:0]  pick,
  output logic          valid
);

  // scan all requesters starting from mask_start, wrapping around
  always_comb begin : p_pick
    int idx;
    idx   = 0;
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(mask_start) + k) % N;
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ub_access_arbiter.sv
// Round-robin arbiter sharing the UB byte port among requesters.
// Locked bursts, hold cap, read data steered back by tag pipe.
module ub_access_arbiter
  import ub_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                          CLK,
  input  logic                          ASYNC_RST,
  input  logic                          SYNC_RST,
  input  logic                          EN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          UB_en,
  output logic                          UB_wren,
  output logic [ADDR_WIDTH-1:0]         UB_wraddr,
  output logic [DATA_WIDTH-1:0]         UB_wrdata,
  output logic [ADDR_WIDTH-1:0]         UB_rdaddr,
  input  logic [DATA_WIDTH-1:0]         UB_rddata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } tag_t;

  arb_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  tag_t [RD_LATENCY-1:0] tag_q, tag_d;

  logic [IW-1:0]      own_idx;
  logic [IW-1:0]      nxt_ptr;
  logic               own_req;
  logic               own_lock;
  logic               own_wr;
  logic               beat;
  logic               owned;
  logic [NUM_REQ-1:0] pk_req;
  logic [IW-1:0]      pk_start;
  logic [NUM_REQ-1:0] pk_oh;
  logic               pk_vld;

  assign own_idx  = IW'(onehot2idx(MAX_REQ'(gnt_q)));
  assign nxt_ptr  = (own_idx == IW'(NUM_REQ - 1)) ? '0 : own_idx + IW'(1);
  assign own_req  = req[own_idx];
  assign own_lock = lock[own_idx];
  assign own_wr   = wr[own_idx];
  assign owned    = (state_q == ARB_OWNED);
  assign beat     = EN && owned && own_req;

  // successor search excludes the current owner and starts after it
  assign pk_req   = owned ? (req & ~gnt_q) : req;
  assign pk_start = owned ? nxt_ptr : rr_ptr_q;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (pk_req),
    .mask_start (pk_start),
    .pick       (pk_oh),
    .valid      (pk_vld)
  );

  // grant FSM: pick an owner, count beats, hand over on release
  always_comb begin
    logic rel;
    logic cap;
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    rel      = 1'b0;
    cap      = 1'b0;
    if (EN) begin
      if (SYNC_RST) begin
        state_d  = ARB_IDLE;
        gnt_d    = '0;
        rr_ptr_d = '0;
        hold_d   = '0;
      end else begin
        unique case (state_q)
          ARB_IDLE: begin
            if (pk_vld) begin
              state_d = ARB_OWNED;
              gnt_d   = pk_oh;
              hold_d  = '0;
            end
          end
          ARB_OWNED: begin
            if (!own_req) begin
              rel = 1'b1;
            end else if (!own_lock) begin
              rel = 1'b1;
            end else if (hold_q == HW'(MAX_HOLD - 1)) begin
              rel = 1'b1;
              cap = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
            if (rel) begin
              hold_d   = '0;
              rr_ptr_d = nxt_ptr;
              if (pk_vld) begin
                gnt_d = pk_oh;
              end else if (cap) begin
                gnt_d = gnt_q;
              end else begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  // read tag pipe: one entry per cycle of UB read latency
  always_comb begin
    tag_d = tag_q;
    if (EN) begin
      if (SYNC_RST) begin
        tag_d = '0;
      end else begin
        tag_d[0].v  = beat && !own_wr;
        tag_d[0].id = own_idx;
        for (int k = 1; k < RD_LATENCY; k++) begin
          tag_d[k] = tag_q[k-1];
        end
      end
    end
  end

  // UB port mux from the registered owner, plus read return steering
  always_comb begin
    UB_en     = 1'b0;
    UB_wren   = 1'b0;
    UB_wraddr = '0;
    UB_rdaddr = '0;
    UB_wrdata = '0;
    rvalid    = '0;
    rdata     = '0;
    if (beat) begin
      UB_en     = 1'b1;
      UB_wren   = own_wr;
      UB_wraddr = addr[int'(own_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      UB_rdaddr = addr[int'(own_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      UB_wrdata = wdata[int'(own_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (tag_q[RD_LATENCY-1].v) begin
      rdata = UB_rddata;
      for (int i = 0; i < NUM_REQ; i++) begin
        rvalid[i] = (tag_q[RD_LATENCY-1].id == IW'(i));
      end
    end
  end

  assign gnt = gnt_q & {NUM_REQ{EN}};

  // state registers
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_ub_access_arbiter.sv
// Directed bench for ub_access_arbiter.
// Two instances: default hold cap and a cap of 4.
module tb_ub_access_arbiter;

  localparam int N  = 3;
  localparam int AW = 21;
  localparam int DW = 8;

  logic          CLK;
  logic          ASYNC_RST;
  logic          SYNC_RST;
  logic          EN;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N-1:0]  wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] UB_rddata;

  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          UB_en, UB_wren;
  logic [AW-1:0] UB_wraddr, UB_rdaddr;
  logic [DW-1:0] UB_wrdata;

  logic [N-1:0]  gnt4, rvalid4;
  logic [DW-1:0] rdata4;
  logic          UB_en4, UB_wren4;
  logic [AW-1:0] UB_wraddr4, UB_rdaddr4;
  logic [DW-1:0] UB_wrdata4;

  int errs;
  int checks;

  ub_access_arbiter u_dut (
    .CLK       (CLK),
    .ASYNC_RST (ASYNC_RST),
    .SYNC_RST  (SYNC_RST),
    .EN        (EN),
    .req       (req),
    .lock      (lock),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .UB_en     (UB_en),
    .UB_wren   (UB_wren),
    .UB_wraddr (UB_wraddr),
    .UB_wrdata (UB_wrdata),
    .UB_rdaddr (UB_rdaddr),
    .UB_rddata (UB_rddata)
  );

  ub_access_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .CLK       (CLK),
    .ASYNC_RST (ASYNC_RST),
    .SYNC_RST  (SYNC_RST),
    .EN        (EN),
    .req       (req),
    .lock      (lock),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt4),
    .rvalid    (rvalid4),
    .rdata     (rdata4),
    .UB_en     (UB_en4),
    .UB_wren   (UB_wren4),
    .UB_wraddr (UB_wraddr4),
    .UB_wrdata (UB_wrdata4),
    .UB_rdaddr (UB_rdaddr4),
    .UB_rddata (UB_rddata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    ASYNC_RST = 1'b0;
    SYNC_RST  = 1'b0;
    EN        = 1'b1;
    req       = '0;
    lock      = '0;
    wr        = '0;
    addr      = {21'h000200, 21'h000100, 21'h000000};
    wdata     = '0;
    UB_rddata = 8'h3C;

    // reset state
    cyc(); cyc();
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ub_en", 32'(UB_en), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdaddr", 32'(UB_rdaddr), 0);
    cyc();
    ASYNC_RST = 1'b1;
    #2;
    check("idle_gnt", 32'(gnt), 0);

    // round robin, no lock, back-to-back reads
    cyc(); req = 3'b111; #2;
    check("t2_first_gnt", 32'(gnt), 0);
    check("t2_first_en", 32'(UB_en), 0);
    cyc(); #2;
    check("t2_gnt0", 32'(gnt), 3'b001);
    check("t2_en0", 32'(UB_en), 1);
    check("t2_rdaddr0", 32'(UB_rdaddr), 32'h0);
    cyc(); #2;
    check("t2_gnt1", 32'(gnt), 3'b010);
    check("t2_rdaddr1", 32'(UB_rdaddr), 32'h100);
    check("t2_rv0", 32'(rvalid), 3'b001);
    check("t2_rdata0", 32'(rdata), 32'h3C);
    cyc(); #2;
    check("t2_gnt2", 32'(gnt), 3'b100);
    check("t2_rv1", 32'(rvalid), 3'b010);
    check("t2_en2", 32'(UB_en), 1);
    cyc(); #2;
    check("t2_gnt0b", 32'(gnt), 3'b001);
    check("t2_rv2", 32'(rvalid), 3'b100);
    cyc(); req = 3'b000; #2;
    check("t2_drop_gnt", 32'(gnt), 3'b010);
    check("t2_drop_en", 32'(UB_en), 0);
    check("t2_drop_rv", 32'(rvalid), 3'b001);
    cyc(); #2;
    check("t2_idle_gnt", 32'(gnt), 0);
    check("t2_idle_rv", 32'(rvalid), 0);

    // locked burst of 5 beats under cap 16, then handover
    cyc(); req = 3'b011; lock = 3'b001; #2;
    check("t3_idle", 32'(gnt), 0);
    for (int b = 1; b <= 5; b++) begin
      cyc();
      if (b == 5) lock = 3'b000;
      #2;
      check($sformatf("t3_burst%0d", b), 32'(gnt), 3'b001);
    end
    cyc(); req = 3'b010; #2;
    check("t3_handover", 32'(gnt), 3'b010);
    check("t3_rdaddr", 32'(UB_rdaddr), 32'h100);
    cyc(); req = 3'b000; #2;
    check("t3_release", 32'(gnt), 0);

    // asynchronous reset mid-run
    cyc(); req = 3'b001; lock = 3'b001; #2;
    check("t1_idle", 32'(gnt), 0);
    cyc(); #2;
    check("t1_gnt", 32'(gnt), 3'b001);
    cyc(); #2;
    check("t1_rv_before", 32'(rvalid), 3'b001);
    ASYNC_RST = 1'b0;
    #1;
    check("t1_rst_gnt", 32'(gnt), 0);
    check("t1_rst_en", 32'(UB_en), 0);
    check("t1_rst_rv", 32'(rvalid), 0);
    check("t1_rst_rdata", 32'(rdata), 0);
    cyc();
    ASYNC_RST = 1'b1; req = '0; lock = '0;
    #2;
    check("t1_post_gnt", 32'(gnt), 0);
    cyc(); #2;
    check("t1_post_idle", 32'(gnt), 0);

    // hold cap of 4 forces handover, then sole requester regrant
    cyc(); req = 3'b011; lock = 3'b001; #2;
    check("t4_idle", 32'(gnt4), 0);
    for (int b = 1; b <= 4; b++) begin
      cyc(); #2;
      check($sformatf("t4_beat%0d", b), 32'(gnt4), 3'b001);
    end
    cyc(); #2;
    check("t4_cap_gnt1", 32'(gnt4), 3'b010);
    check("t4_nocap16", 32'(gnt), 3'b001);
    cyc(); req = 3'b001; #2;
    check("t4_back0", 32'(gnt4), 3'b001);
    for (int b = 7; b <= 10; b++) begin
      cyc(); #2;
      check($sformatf("t4_sole%0d", b), 32'(gnt4), 3'b001);
    end
    check("t4_sole_en", 32'(UB_en4), 1);
    cyc(); req = '0; lock = '0; #2;
    cyc(); #2;
    check("t4_end", 32'(gnt4), 0);

    // read return to requester 2, then a write with no return
    cyc();
    req = 3'b100; wr = 3'b000;
    addr = {21'h000010, 21'h000100, 21'h000000};
    UB_rddata = 8'hA5;
    #2;
    check("t5_idle", 32'(gnt), 0);
    cyc(); #2;
    check("t5_gnt", 32'(gnt), 3'b100);
    check("t5_en", 32'(UB_en), 1);
    check("t5_wren", 32'(UB_wren), 0);
    check("t5_rdaddr", 32'(UB_rdaddr), 32'h10);
    cyc(); req = 3'b000; #2;
    check("t5_rvalid", 32'(rvalid), 3'b100);
    check("t5_rdata", 32'(rdata), 32'hA5);
    check("t5_gnt_off", 32'(gnt), 0);
    cyc();
    req = 3'b100; wr = 3'b100;
    addr = {21'h000022, 21'h000100, 21'h000000};
    wdata = {8'h5A, 8'h00, 8'h00};
    #2;
    check("t5w_idle", 32'(gnt), 0);
    cyc(); #2;
    check("t5w_gnt", 32'(gnt), 3'b100);
    check("t5w_wren", 32'(UB_wren), 1);
    check("t5w_wraddr", 32'(UB_wraddr), 32'h22);
    check("t5w_wrdata", 32'(UB_wrdata), 32'h5A);
    cyc(); req = '0; wr = '0; #2;
    check("t5w_no_rv", 32'(rvalid), 0);

    // synchronous reset on a read beat drops the return
    cyc(); req = 3'b001; lock = 3'b001; #2;
    check("t6_idle", 32'(gnt), 0);
    cyc(); SYNC_RST = 1'b1; #2;
    check("t6_beat_gnt", 32'(gnt), 3'b001);
    check("t6_beat_en", 32'(UB_en), 1);
    cyc(); SYNC_RST = 1'b0; req = '0; lock = '0; #2;
    check("t6_no_rv", 32'(rvalid), 0);
    check("t6_gnt_off", 32'(gnt), 0);

    // enable low freezes a burst mid-way
    cyc(); req = 3'b011; lock = 3'b001; #2;
    check("t6e_idle", 32'(gnt4), 0);
    cyc(); #2;
    check("t6e_beat1", 32'(gnt4), 3'b001);
    cyc(); #2;
    check("t6e_beat2", 32'(gnt4), 3'b001);
    for (int c = 0; c < 3; c++) begin
      cyc(); EN = 1'b0; #2;
      check($sformatf("t6e_frz_gnt%0d", c), 32'(gnt4), 0);
      check($sformatf("t6e_frz_en%0d", c), 32'(UB_en4), 0);
    end
    cyc(); EN = 1'b1; #2;
    check("t6e_beat3", 32'(gnt4), 3'b001);
    check("t6e_beat3_en", 32'(UB_en4), 1);
    cyc(); #2;
    check("t6e_beat4", 32'(gnt4), 3'b001);
    cyc(); #2;
    check("t6e_cap", 32'(gnt4), 3'b010);
    check("t6e_nocap16", 32'(gnt), 3'b001);
    cyc(); req = '0; lock = '0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
